// File: rtl/aes_cbc_decryptor.sv
// rtl/aes_cbc_decryptor.sv - iterative AES-128 CBC decryptor with cached round keys
// One inverse round per clock; round keys are expanded once per key and reused while the key is unchanged.

module aes_gf_inv (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  logic [7:0] sq;
  logic [7:0] acc;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 = a^-1 in GF(2^8); maps 0 to 0 as the S-box requires
  always_comb begin
    sq  = a_i;
    acc = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      acc = gmul(acc, sq);
    end
    y_o = acc;
  end
endmodule

module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  logic [7:0] inv;

  aes_gf_inv u_inv (.a_i(a_i), .y_o(inv));

  assign y_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module aes_inv_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  logic [7:0] pre;

  assign pre = {a_i[6:0], a_i[7]} ^ {a_i[4:0], a_i[7:5]} ^ {a_i[1:0], a_i[7:2]} ^ 8'h05;

  aes_gf_inv u_inv (.a_i(pre), .y_o(y_o));
endmodule

module aes_cbc_decryptor #(
  parameter logic [127:0] INITIAL_VEC = 128'h000102030405060708090A0B0C0D0E0F
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] datain,
  input  logic         dat_stb,
  input  logic [127:0] key,
  input  logic         key_valid,
  input  logic         o_stb,
  output logic         o_valid,
  output logic [127:0] dataout,
  output logic         ready
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_KEYEXP = 2'd1;
  localparam logic [1:0] S_ROUNDS = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]   state_q, state_d;
  logic [3:0]   kcnt_q, kcnt_d;
  logic [3:0]   r_q, r_d;
  logic [127:0] st_q, st_d;
  logic [127:0] ct_q, ct_d;
  logic [127:0] k_q, k_d;
  logic [127:0] chain_q, chain_d;
  logic [127:0] ckey_q, ckey_d;
  logic         cvalid_q, cvalid_d;
  logic [127:0] dout_q, dout_d;
  logic         ov_q, ov_d;
  logic         ready_q, ready_d;
  logic [127:0] rk_q [0:10];
  logic [127:0] rk_d [0:10];

  logic         accept;
  logic         hit;
  logic [3:0]   prev_idx;
  logic [127:0] prev_rk;
  logic [31:0]  sub_out;
  logic [7:0]   rcon;
  logic [31:0]  tw;
  logic [127:0] new_rk;
  logic [127:0] isb;
  logic [127:0] rnd_add;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a [0:3];
    logic [7:0] m9 [0:3];
    logic [7:0] m11 [0:3];
    logic [7:0] m13 [0:3];
    logic [7:0] m14 [0:3];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]   = c[31-8*i -: 8];
      x2     = xt(a[i]);
      x4     = xt(x2);
      x8     = xt(x4);
      m9[i]  = x8 ^ a[i];
      m11[i] = x8 ^ x2 ^ a[i];
      m13[i] = x8 ^ x4 ^ a[i];
      m14[i] = x8 ^ x4 ^ x2;
    end
    return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
            m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
            m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
            m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    return o;
  endfunction

  assign accept = ready_q && dat_stb && key_valid;
  assign hit    = cvalid_q && (key == ckey_q);

  // Forward key schedule step from the previous round key
  assign prev_idx = (kcnt_q == 4'd0) ? 4'd0 : kcnt_q - 4'd1;
  assign prev_rk  = rk_q[prev_idx];

  always_comb begin
    case (kcnt_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  aes_sbox u_ks0 (.a_i(prev_rk[23:16]), .y_o(sub_out[31:24]));
  aes_sbox u_ks1 (.a_i(prev_rk[15:8]),  .y_o(sub_out[23:16]));
  aes_sbox u_ks2 (.a_i(prev_rk[7:0]),   .y_o(sub_out[15:8]));
  aes_sbox u_ks3 (.a_i(prev_rk[31:24]), .y_o(sub_out[7:0]));

  assign tw              = sub_out ^ {rcon, 24'h000000};
  assign new_rk[127:96]  = prev_rk[127:96] ^ tw;
  assign new_rk[95:64]   = prev_rk[95:64]  ^ new_rk[127:96];
  assign new_rk[63:32]   = prev_rk[63:32]  ^ new_rk[95:64];
  assign new_rk[31:0]    = prev_rk[31:0]   ^ new_rk[63:32];

  // InvShiftRows folded into the S-box input wiring: row r rotates right by r columns
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int DST = 4 * c + r;
      localparam int SRC = 4 * ((c + 4 - r) % 4) + r;
      aes_inv_sbox u_isb (.a_i(st_q[127-8*SRC -: 8]), .y_o(isb[127-8*DST -: 8]));
    end
  end

  assign rnd_add = isb ^ rk_q[r_q];

  always_comb begin
    state_d  = state_q;
    kcnt_d   = kcnt_q;
    r_d      = r_q;
    st_d     = st_q;
    ct_d     = ct_q;
    k_d      = k_q;
    chain_d  = chain_q;
    ckey_d   = ckey_q;
    cvalid_d = cvalid_q;
    dout_d   = dout_q;
    ov_d     = ov_q;
    ready_d  = ready_q;
    for (int i = 0; i < 11; i++) rk_d[i] = rk_q[i];
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          ct_d    = datain;
          k_d     = key;
          ready_d = 1'b0;
          if (hit) begin
            st_d    = datain ^ rk_q[10];
            r_d     = 4'd9;
            state_d = S_ROUNDS;
          end else begin
            rk_d[0]  = key;
            kcnt_d   = 4'd1;
            cvalid_d = 1'b0;
            state_d  = S_KEYEXP;
          end
        end
      end
      S_KEYEXP: begin
        rk_d[kcnt_q] = new_rk;
        kcnt_d       = kcnt_q + 4'd1;
        if (kcnt_q == 4'd10) begin
          ckey_d   = k_q;
          cvalid_d = 1'b1;
          st_d     = ct_q ^ new_rk;
          r_d      = 4'd9;
          state_d  = S_ROUNDS;
        end
      end
      S_ROUNDS: begin
        if (r_q == 4'd0) begin
          dout_d  = rnd_add ^ chain_q;
          ov_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          st_d = inv_mix(rnd_add);
          r_d  = r_q - 4'd1;
        end
      end
      S_DONE: begin
        if (o_stb) begin
          ov_d    = 1'b0;
          chain_d = ct_q;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      kcnt_q   <= 4'd0;
      r_q      <= 4'd0;
      st_q     <= '0;
      ct_q     <= '0;
      k_q      <= '0;
      chain_q  <= INITIAL_VEC;
      ckey_q   <= '0;
      cvalid_q <= 1'b0;
      dout_q   <= '0;
      ov_q     <= 1'b0;
      ready_q  <= 1'b1;
      for (int i = 0; i < 11; i++) rk_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      kcnt_q   <= kcnt_d;
      r_q      <= r_d;
      st_q     <= st_d;
      ct_q     <= ct_d;
      k_q      <= k_d;
      chain_q  <= chain_d;
      ckey_q   <= ckey_d;
      cvalid_q <= cvalid_d;
      dout_q   <= dout_d;
      ov_q     <= ov_d;
      ready_q  <= ready_d;
      for (int i = 0; i < 11; i++) rk_q[i] <= rk_d[i];
    end
  end

  assign o_valid = ov_q;
  assign dataout = dout_q;
  assign ready   = ready_q;
endmodule
